// File: rtl/cnn_accel_pkg.sv
// ---------------------------------------------------------------------------
// cnn_accel_pkg
// Shared constants for the CNN accelerator bus-side blocks: register offsets,
// STATUS register field positions and default widths.
// ---------------------------------------------------------------------------
package cnn_accel_pkg;

    // Default widths
    localparam int DATA_W     = 32;  // one result element (FRAC_WIDTH+EXP_WIDTH)
    localparam int BUS_DATA_W = 64;  // one bus word = two packed elements
    localparam int BUS_ADDR_W = 32;
    localparam int TOTAL_W    = 12;  // total-words counter

    // Register map: only address bit 3 is decoded
    localparam int                  ADDR_SEL_BIT  = 3;
    localparam logic [BUS_ADDR_W-1:0] DATA_OFFSET   = 32'h0000_0000;
    localparam logic [BUS_ADDR_W-1:0] STATUS_OFFSET = 32'h0000_0008;

    typedef enum logic {
        REG_DATA   = 1'b0,
        REG_STATUS = 1'b1
    } regSel_e;

    // STATUS register layout
    localparam int COUNT_LO  = 0;
    localparam int COUNT_HI  = 15;
    localparam int PEND_BIT  = 16;
    localparam int DONE_BIT  = 17;
    localparam int UFLOW_BIT = 18;
    localparam int TOTAL_LO  = 20;
    localparam int TOTAL_HI  = 31;

endpackage : cnn_accel_pkg

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Synchronous first-word-fall-through FIFO for packed result words.
// Ports:
//   clkIn, rstNIn   clock, asynchronous active-low reset
//   clr             synchronous clear, wins over push and pop
//   push, wrData    write request and data (ignored when full unless popping)
//   pop             read request; rdData shows the head combinationally
//   full, empty     occupancy flags
//   count           current word count
//   countNext       word count after this cycle's push/pop/clr
// ---------------------------------------------------------------------------
module result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clkIn,
    input  logic             rstNIn,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wrData,
    input  logic             pop,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    countNext
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign rdData = mem[rdPtr];

    // A full FIFO may still accept a push when the head leaves in the same
    // cycle: the write lands in the slot being vacated.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        countNext = count;
        if (clr) begin
            countNext = '0;
        end else begin
            case ({doPush, doPop})
                2'b10:   countNext = count + CW'(1);
                2'b01:   countNext = count - CW'(1);
                default: countNext = count;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= countNext;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clkIn) begin
        if (doPush && !clr) begin
            mem[wrPtr] <= wrData;
        end
    end

endmodule : result_fifo

// File: rtl/cnn_result_reader.sv
// ---------------------------------------------------------------------------
// cnn_result_reader
// Drains the accelerator's 32-bit result stream, packs element pairs into
// 64-bit bus words, buffers them and serves them to the core over bus reads.
// Ports:
//   clkIn, rstNIn            clock, asynchronous active-low reset
//   dataIn/validIn/lastIn    result element stream; readyOut is backpressure
//   clrIn                    synchronous soft clear
//   addrIn, rdEnIn           bus read request (bit 3: 0=DATA pop, 1=STATUS)
//   rdDataOut, rdAckOut      read response, one cycle after rdEnIn
//   emptyOut                 FIFO empty
// ---------------------------------------------------------------------------
module cnn_result_reader
    import cnn_accel_pkg::*;
#(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_WIDTH      = 12
) (
    input  logic                      clkIn,
    input  logic                      rstNIn,
    input  logic [DATA_WIDTH-1:0]     dataIn,
    input  logic                      validIn,
    input  logic                      lastIn,
    output logic                      readyOut,
    input  logic                      clrIn,
    input  logic [BUS_ADDR_WIDTH-1:0] addrIn,
    input  logic                      rdEnIn,
    output logic [BUS_DATA_WIDTH-1:0] rdDataOut,
    output logic                      rdAckOut,
    output logic                      emptyOut
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Pack stage state
    logic [DATA_WIDTH-1:0]     lowR;
    logic                      pendingR;
    logic                      doneR;
    logic                      underflowR;
    logic [CNT_WIDTH-1:0]      totalR;
    logic                      readyR;

    // Datapath
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic [BUS_DATA_WIDTH-1:0] pushData;
    logic [BUS_DATA_WIDTH-1:0] headData;
    logic [BUS_DATA_WIDTH-1:0] statusWord;
    logic [BUS_DATA_WIDTH-1:0] readData;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic [CW-1:0]             fifoCount;
    logic [CW-1:0]             fifoCountNext;
    regSel_e                   regSel;

    // Only address bit 3 selects a register; the rest is ignored.
    logic unusedSignals;
    assign unusedSignals = ^{addrIn, fifoFull};

    assign regSel   = regSel_e'(addrIn[ADDR_SEL_BIT]);
    assign readyOut = readyR;
    assign emptyOut = fifoEmpty;

    always_comb begin
        // A clear cycle refuses the element whatever readyOut says.
        accept   = validIn & readyR & ~clrIn;
        push     = accept & (pendingR | lastIn);
        pushData = pendingR ? {dataIn, lowR} : {{DATA_WIDTH{1'b0}}, dataIn};
        pop      = rdEnIn & (regSel == REG_DATA) & ~fifoEmpty & ~clrIn;
    end

    result_fifo #(
        .WIDTH (BUS_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) uFifo (
        .clkIn     (clkIn),
        .rstNIn    (rstNIn),
        .clr       (clrIn),
        .push      (push),
        .wrData    (pushData),
        .pop       (pop),
        .rdData    (headData),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .count     (fifoCount),
        .countNext (fifoCountNext)
    );

    always_comb begin
        statusWord                     = '0;
        statusWord[COUNT_HI:COUNT_LO]  = 16'(fifoCount);
        statusWord[PEND_BIT]           = pendingR;
        statusWord[DONE_BIT]           = doneR;
        statusWord[UFLOW_BIT]          = underflowR;
        statusWord[TOTAL_HI:TOTAL_LO]  = 12'(totalR);

        readData = '0;
        if (regSel == REG_STATUS) begin
            readData = statusWord;
        end else if (!clrIn && !fifoEmpty) begin
            readData = headData;
        end
    end

    // Pack stage. readyOut looks at next cycle's occupancy so a push can
    // never arrive while the FIFO is full.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            lowR     <= '0;
            pendingR <= 1'b0;
            doneR    <= 1'b0;
            totalR   <= '0;
            readyR   <= 1'b0;
        end else begin
            readyR <= (fifoCountNext != CW'(FIFO_DEPTH));
            if (clrIn) begin
                pendingR <= 1'b0;
                doneR    <= 1'b0;
                totalR   <= '0;
            end else if (accept) begin
                if (!pendingR && !lastIn) begin
                    lowR     <= dataIn;
                    pendingR <= 1'b1;
                end else begin
                    pendingR <= 1'b0;
                end
                if (lastIn) doneR <= 1'b1;
                if (push && (totalR != '1)) totalR <= totalR + CNT_WIDTH'(1);
            end
        end
    end

    // Bus read side: fixed one-cycle latency, data held between acks.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            rdDataOut  <= '0;
            rdAckOut   <= 1'b0;
            underflowR <= 1'b0;
        end else begin
            rdAckOut <= rdEnIn;
            if (rdEnIn) rdDataOut <= readData;
            if (clrIn) begin
                underflowR <= 1'b0;
            end else if (rdEnIn && (regSel == REG_DATA) && fifoEmpty) begin
                underflowR <= 1'b1;
            end
        end
    end

endmodule : cnn_result_reader

// File: tb/tb_cnn_result_reader.sv
// ---------------------------------------------------------------------------
// tb_cnn_result_reader
// Directed bench for cnn_result_reader: packing, DATA/STATUS reads,
// underflow, soft clear, backpressure with a full FIFO and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_cnn_result_reader;

    localparam int DEPTH = 16;

    logic        clkIn   = 1'b0;
    logic        rstNIn  = 1'b0;
    logic [31:0] dataIn  = '0;
    logic        validIn = 1'b0;
    logic        lastIn  = 1'b0;
    logic        readyOut;
    logic        clrIn   = 1'b0;
    logic [31:0] addrIn  = '0;
    logic        rdEnIn  = 1'b0;
    logic [63:0] rdDataOut;
    logic        rdAckOut;
    logic        emptyOut;

    int checks = 0;
    int errors = 0;

    // Scoreboard for the backpressure phase: words built from accepted elements.
    logic [63:0] expQ[$];
    logic [31:0] lowHold;
    logic        havePending = 1'b0;

    cnn_result_reader #(
        .BUS_ADDR_WIDTH (32),
        .BUS_DATA_WIDTH (64),
        .DATA_WIDTH     (32),
        .FIFO_DEPTH     (DEPTH),
        .CNT_WIDTH      (12)
    ) dut (
        .clkIn     (clkIn),
        .rstNIn    (rstNIn),
        .dataIn    (dataIn),
        .validIn   (validIn),
        .lastIn    (lastIn),
        .readyOut  (readyOut),
        .clrIn     (clrIn),
        .addrIn    (addrIn),
        .rdEnIn    (rdEnIn),
        .rdDataOut (rdDataOut),
        .rdAckOut  (rdAckOut),
        .emptyOut  (emptyOut)
    );

    always #5 clkIn = ~clkIn;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, actual, expected);
        end
    endtask

    // One bus read; called #1 after an edge, returns #1 after the ack edge.
    task automatic busRead(input string tag, input logic isStatus, output logic [63:0] data);
        addrIn = isStatus ? 32'h0000_0008 : 32'h0000_0000;
        rdEnIn = 1'b1;
        @(posedge clkIn);
        #1;
        rdEnIn = 1'b0;
        check({tag, "_ack"}, 64'(rdAckOut), 64'd1);
        data = rdDataOut;
    endtask

    // Offer one element until accepted (bounded).
    task automatic sendElem(input logic [31:0] d, input logic last);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        validIn  = 1'b1;
        dataIn   = d;
        lastIn   = last;
        for (int i = 0; i < 20 && !accepted; i++) begin
            rdy = readyOut;
            @(posedge clkIn);
            #1;
            accepted = rdy;
        end
        validIn = 1'b0;
        lastIn  = 1'b0;
        if (!accepted) check("send_timeout", 64'(accepted), 64'd1);
    endtask

    task automatic modelAccept(input logic [31:0] d);
        if (havePending) begin
            expQ.push_back({d, lowHold});
            havePending = 1'b0;
        end else begin
            lowHold     = d;
            havePending = 1'b1;
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] expWord;
        logic        rdy;
        int          n;

        // ---- Reset state ----
        #1;
        check("rst_ready", 64'(readyOut), 64'd0);
        check("rst_empty", 64'(emptyOut), 64'd1);
        check("rst_ack",   64'(rdAckOut), 64'd0);
        #11 rstNIn = 1'b1;
        @(posedge clkIn);
        #1;
        check("ready_after_rst", 64'(readyOut), 64'd1);

        // ---- Pair with last on the second element ----
        sendElem(32'h3F80_0000, 1'b0);
        sendElem(32'h4000_0000, 1'b1);
        busRead("pair_data", 1'b0, rd);
        check("pair_data", rd, 64'h4000_0000_3F80_0000);
        busRead("pair_status", 1'b1, rd);
        check("pair_status", rd, 64'h0000_0000_0012_0000);
        @(posedge clkIn);
        #1;
        check("idle_ack", 64'(rdAckOut), 64'd0);
        check("hold_data", rdDataOut, 64'h0000_0000_0012_0000);

        // ---- Three elements, last on the odd one ----
        sendElem(32'h1111_1111, 1'b0);
        sendElem(32'h2222_2222, 1'b0);
        sendElem(32'h3333_3333, 1'b1);
        busRead("abc_w0", 1'b0, rd);
        check("abc_w0", rd, 64'h2222_2222_1111_1111);
        busRead("abc_status", 1'b1, rd);
        check("abc_status", rd, 64'h0000_0000_0032_0001);
        busRead("abc_w1", 1'b0, rd);
        check("abc_w1", rd, 64'h0000_0000_3333_3333);

        // ---- Underflow, then clear ----
        busRead("uflow", 1'b0, rd);
        check("uflow_data", rd, 64'd0);
        busRead("uflow_status", 1'b1, rd);
        check("uflow_status", rd, 64'h0000_0000_0036_0000);
        // Clear cycle with an offered element and a DATA read on empty FIFO.
        clrIn   = 1'b1;
        validIn = 1'b1;
        lastIn  = 1'b1;
        dataIn  = 32'hDEAD_BEEF;
        busRead("clr_read", 1'b0, rd);
        clrIn   = 1'b0;
        validIn = 1'b0;
        lastIn  = 1'b0;
        check("clr_read_data", rd, 64'd0);
        busRead("clr_status", 1'b1, rd);
        check("clr_status", rd, 64'd0);
        check("clr_empty", 64'(emptyOut), 64'd1);

        // ---- Backpressure: hold validIn with no reads ----
        lastIn  = 1'b0;
        validIn = 1'b1;
        n       = 1;
        dataIn  = 32'hA000_0000 + 32'(n);
        for (int c = 0; c < 40; c++) begin
            rdy = readyOut;
            @(posedge clkIn);
            #1;
            if (rdy) begin
                modelAccept(dataIn);
                n++;
                dataIn = 32'hA000_0000 + 32'(n);
            end
        end
        check("fill_accepts", 64'(n - 1), 64'd32);
        check("fill_ready",   64'(readyOut), 64'd0);
        check("fill_empty",   64'(emptyOut), 64'd0);
        busRead("fill_status", 1'b1, rd);
        check("fill_status", rd, 64'h0000_0000_0100_0010);

        // One pop frees a slot; readyOut returns on the next cycle.
        busRead("free_data", 1'b0, rd);
        expWord = expQ.pop_front();
        check("free_data", rd, expWord);
        check("free_ready", 64'(readyOut), 64'd1);

        // Element 33 goes to the low half.
        rdy = readyOut;
        @(posedge clkIn);
        #1;
        check("e33_accept", 64'(rdy), 64'd1);
        if (rdy) begin
            modelAccept(dataIn);
            n++;
            dataIn = 32'hA000_0000 + 32'(n);
        end

        // Element 34 completes a word in the same cycle as a DATA pop.
        addrIn = 32'h0;
        rdEnIn = 1'b1;
        rdy    = readyOut;
        @(posedge clkIn);
        #1;
        rdEnIn  = 1'b0;
        validIn = 1'b0;
        if (rdy) modelAccept(dataIn);
        check("pushpop_ack", 64'(rdAckOut), 64'd1);
        expWord = expQ.pop_front();
        check("pushpop_data", rdDataOut, expWord);
        busRead("pushpop_status", 1'b1, rd);
        check("pushpop_status", rd, 64'h0000_0000_0110_000F);

        // Back-to-back drain of the remaining 15 words.
        addrIn = 32'h0;
        rdEnIn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clkIn);
            #1;
            check($sformatf("burst_ack%0d", i), 64'(rdAckOut), 64'd1);
            expWord = (expQ.size() > 0) ? expQ.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
            check($sformatf("burst_data%0d", i), rdDataOut, expWord);
        end
        rdEnIn = 1'b0;
        check("burst_empty", 64'(emptyOut), 64'd1);
        check("last_word", expWord, 64'hA000_0022_A000_0021);

        // ---- Reset in the middle of a transfer ----
        sendElem(32'h0000_0001, 1'b0);
        sendElem(32'h0000_0002, 1'b0);
        sendElem(32'h0000_0003, 1'b0);
        sendElem(32'h0000_0004, 1'b0);
        sendElem(32'h0000_0005, 1'b0);
        busRead("mid_data", 1'b0, rd);
        check("mid_data", rd, 64'h0000_0002_0000_0001);
        check("mid_empty_pre", 64'(emptyOut), 64'd0);
        #3 rstNIn = 1'b0;
        #1;
        check("mid_rst_ready", 64'(readyOut), 64'd0);
        check("mid_rst_empty", 64'(emptyOut), 64'd1);
        check("mid_rst_ack",   64'(rdAckOut), 64'd0);
        check("mid_rst_data",  rdDataOut, 64'd0);
        #3 rstNIn = 1'b1;
        @(posedge clkIn);
        #1;
        check("post_rst_ready", 64'(readyOut), 64'd1);
        busRead("post_rst_status", 1'b1, rd);
        check("post_rst_status", rd, 64'd0);
        busRead("post_rst_data", 1'b0, rd);
        check("post_rst_data", rd, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cnn_result_reader
